// File: rtl/picosoc_pkg.sv
// Shared constants and FSM encoding for the PicoSoC-style iomem bus initiator.
package picosoc_pkg;

   localparam int IOMEM_ADDR_W = 32;
   localparam int IOMEM_DATA_W = 32;
   localparam int IOMEM_STRB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } initiator_state_t;

endpackage

// File: rtl/iomem_initiator_if.sv
// iomem bus bundle: master drives the request, slave returns ready/rdata.
interface iomem_initiator_if;
   import picosoc_pkg::*;

   logic                    iomem_valid;
   logic                    iomem_ready;
   logic [IOMEM_STRB_W-1:0] iomem_wstrb;
   logic [IOMEM_ADDR_W-1:0] iomem_addr;
   logic [IOMEM_DATA_W-1:0] iomem_wdata;
   logic [IOMEM_DATA_W-1:0] iomem_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );

endinterface

// File: rtl/iomem_initiator.sv
// Command/response front end that issues one iomem access at a time, with a
// bounded wait on iomem_ready that turns into an error response.
module iomem_initiator
   import picosoc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [IOMEM_ADDR_W-1:0] cmd_addr,
   input  logic [IOMEM_DATA_W-1:0] cmd_wdata,
   input  logic [IOMEM_STRB_W-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IOMEM_DATA_W-1:0] rsp_rdata,
   output logic                    rsp_error,
   iomem_initiator_if.master       iomem
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   initiator_state_t state_reg, state_next;

   logic                    cmd_ready_reg;
   logic                    rsp_valid_reg;
   logic                    rsp_error_reg;
   logic [IOMEM_DATA_W-1:0] rsp_rdata_reg;
   logic                    valid_reg;
   logic [IOMEM_ADDR_W-1:0] addr_reg;
   logic [IOMEM_DATA_W-1:0] wdata_reg;
   logic [IOMEM_STRB_W-1:0] wstrb_reg;
   logic [15:0]             count_reg;

   logic accept, bus_done, timeout, rsp_taken;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      accept     = 1'b0;
      bus_done   = 1'b0;
      timeout    = 1'b0;
      rsp_taken  = 1'b0;
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            accept = cmd_valid && cmd_ready_reg;
            if (accept) state_next = ST_REQ;
         end
         ST_REQ: begin
            // ready outranks a timeout landing on the same edge
            bus_done = iomem.iomem_ready;
            timeout  = !iomem.iomem_ready && (count_reg == TIMEOUT_LAST);
            if (bus_done || timeout) state_next = ST_RSP;
         end
         ST_RSP: begin
            rsp_taken = rsp_ready;
            if (rsp_taken) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Handshake outputs are registered from state_next so they all read 0 in reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_error_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         valid_reg     <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         wstrb_reg     <= '0;
         count_reg     <= '0;
      end else begin
         cmd_ready_reg <= (state_next == ST_IDLE);
         valid_reg     <= (state_next == ST_REQ);
         rsp_valid_reg <= (state_next == ST_RSP);
         if (accept) begin
            addr_reg  <= {cmd_addr[IOMEM_ADDR_W-1:2], 2'b00};
            wdata_reg <= cmd_wdata;
            wstrb_reg <= cmd_wstrb;
            count_reg <= '0;
         end else if (state_reg == ST_REQ) begin
            count_reg <= count_reg + 16'd1;
         end
         if (bus_done) begin
            rsp_rdata_reg <= iomem.iomem_rdata;
            rsp_error_reg <= 1'b0;
         end else if (timeout) begin
            rsp_rdata_reg <= '0;
            rsp_error_reg <= 1'b1;
         end
      end
   end

   assign cmd_ready         = cmd_ready_reg;
   assign rsp_valid         = rsp_valid_reg;
   assign rsp_rdata         = rsp_rdata_reg;
   assign rsp_error         = rsp_error_reg;
   assign iomem.iomem_valid = valid_reg;
   assign iomem.iomem_addr  = addr_reg;
   assign iomem.iomem_wdata = wdata_reg;
   assign iomem.iomem_wstrb = wstrb_reg;

endmodule
